// File: rtl/flight_physics_fp.sv
// Bird vertical physics in signed fixed point, stepped once per FrameTick, with INIT/FLIGHT/CRASH control.
// Optional flap lockout is compiled in when FLAP_COOLDOWN_EN is defined.
module flight_physics_fp #(
   parameter int W               = 10,
   parameter int FRAC            = 4,
   parameter int GRAVITY         = 8,
   parameter int JUMP_VEL        = -96,
   parameter int MAX_FALL        = 160,
   parameter int Y_MIN           = 0,
   parameter int Y_MAX           = 464,
   parameter int X_START         = 300,
   parameter int Y_START         = 240,
   parameter int COOLDOWN_FRAMES = 4
) (
   input  logic                       Clk,
   input  logic                       reset_n,
   input  logic                       Start,
   input  logic                       Ack,
   input  logic                       BtnPress,
   input  logic                       FrameTick,
   output logic signed [W+FRAC-1:0]   VertSpeed,
   output logic signed [W-1:0]        Bird_X,
   output logic signed [W-1:0]        Bird_Y,
   output logic                       Crashed,
   output logic [1:0]                 State
);

   localparam int VW = W + FRAC;

   localparam logic [1:0] S_INIT   = 2'b00;
   localparam logic [1:0] S_FLIGHT = 2'b01;
   localparam logic [1:0] S_CRASH  = 2'b10;

   localparam logic signed [VW:0]   GRAV_E     = (VW+1)'(GRAVITY);
   localparam logic signed [VW:0]   MAX_E      = (VW+1)'(MAX_FALL);
   localparam logic signed [VW:0]   YMIN_E     = (VW+1)'(Y_MIN << FRAC);
   localparam logic signed [VW:0]   YMAX_E     = (VW+1)'(Y_MAX << FRAC);
   localparam logic signed [VW-1:0] MAX_FP     = VW'(MAX_FALL);
   localparam logic signed [VW-1:0] JUMP_FP    = VW'(JUMP_VEL);
   localparam logic signed [VW-1:0] YMIN_FP    = VW'(Y_MIN << FRAC);
   localparam logic signed [VW-1:0] YMAX_FP    = VW'(Y_MAX << FRAC);
   localparam logic signed [VW-1:0] YSTART_FP  = VW'(Y_START << FRAC);
   localparam logic signed [W-1:0]  YSTART_PIX = W'(Y_START);

   logic [1:0]             state_q, state_d;
   logic signed [VW-1:0]   y_acc_q, y_acc_d;
   logic signed [VW-1:0]   vel_q, vel_d;
   logic signed [W-1:0]    bird_y_q, bird_y_d;
   logic                   btn_q;
   logic                   flap_pend_q, flap_pend_d;

   logic                   rise, rise_ok, flap;
   logic signed [VW:0]     y_sum, v_sum;
   logic signed [VW-1:0]   v_grav;

`ifdef FLAP_COOLDOWN_EN
   localparam int CDW = $clog2(COOLDOWN_FRAMES + 1);
   localparam logic [CDW-1:0] CD_LOAD = CDW'(COOLDOWN_FRAMES);
   logic [CDW-1:0] cd_q, cd_d;
`endif

   always_comb begin
      state_d     = state_q;
      y_acc_d     = y_acc_q;
      vel_d       = vel_q;
      flap_pend_d = flap_pend_q;
      rise        = BtnPress & ~btn_q;
`ifdef FLAP_COOLDOWN_EN
      cd_d        = cd_q;
      rise_ok     = rise & (cd_q == '0);
`else
      rise_ok     = rise;
`endif
      flap   = flap_pend_q | rise_ok;
      y_sum  = {y_acc_q[VW-1], y_acc_q} + {vel_q[VW-1], vel_q};
      v_sum  = {vel_q[VW-1], vel_q} + GRAV_E;
      v_grav = (v_sum > MAX_E) ? MAX_FP : v_sum[VW-1:0];

      case (state_q)
         S_INIT: begin
            if (Start) state_d = S_FLIGHT;
         end
         S_FLIGHT: begin
            if (FrameTick) begin
               flap_pend_d = 1'b0;
`ifdef FLAP_COOLDOWN_EN
               if (cd_q != '0) cd_d = cd_q - 1'b1;
`endif
               // Floor wins over a pending flap; ceiling still honours it.
               if (y_sum >= YMAX_E) begin
                  y_acc_d = YMAX_FP;
                  vel_d   = '0;
                  state_d = S_CRASH;
               end else begin
                  y_acc_d = (y_sum < YMIN_E) ? YMIN_FP : y_sum[VW-1:0];
                  if (flap)               vel_d = JUMP_FP;
                  else if (y_sum < YMIN_E) vel_d = '0;
                  else                    vel_d = v_grav;
`ifdef FLAP_COOLDOWN_EN
                  if (flap) cd_d = CD_LOAD;
`endif
               end
            end else begin
               flap_pend_d = flap;
            end
         end
         S_CRASH: begin
            if (Ack) begin
               state_d = S_INIT;
               y_acc_d = YSTART_FP;
               vel_d   = '0;
`ifdef FLAP_COOLDOWN_EN
               cd_d    = '0;
`endif
            end
         end
         default: state_d = S_INIT;
      endcase

      bird_y_d = y_acc_d[VW-1:FRAC];
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_INIT;
         y_acc_q     <= YSTART_FP;
         vel_q       <= '0;
         bird_y_q    <= YSTART_PIX;
         btn_q       <= 1'b0;
         flap_pend_q <= 1'b0;
`ifdef FLAP_COOLDOWN_EN
         cd_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         y_acc_q     <= y_acc_d;
         vel_q       <= vel_d;
         bird_y_q    <= bird_y_d;
         btn_q       <= BtnPress;
         flap_pend_q <= flap_pend_d;
`ifdef FLAP_COOLDOWN_EN
         cd_q        <= cd_d;
`endif
      end
   end

   assign VertSpeed = vel_q;
   assign Bird_X    = W'(X_START);
   assign Bird_Y    = bird_y_q;
   assign Crashed   = (state_q == S_CRASH);
   assign State     = state_q;

endmodule

// File: tb/tb_flight_physics_fp.sv
// Directed bench for flight_physics_fp with hand-computed expectations; honours FLAP_COOLDOWN_EN.
module tb_flight_physics_fp;

   logic               Clk = 1'b0;
   logic               reset_n;
   logic               Start, Ack, BtnPress, FrameTick;
   logic signed [13:0] VertSpeed;
   logic signed [9:0]  Bird_X, Bird_Y;
   logic               Crashed;
   logic [1:0]         State;

   int passed = 0;
   int total  = 0;

   flight_physics_fp dut (
      .Clk       (Clk),
      .reset_n   (reset_n),
      .Start     (Start),
      .Ack       (Ack),
      .BtnPress  (BtnPress),
      .FrameTick (FrameTick),
      .VertSpeed (VertSpeed),
      .Bird_X    (Bird_X),
      .Bird_Y    (Bird_Y),
      .Crashed   (Crashed),
      .State     (State)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic cycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_tick(input logic press);
      BtnPress  = press;
      FrameTick = 1'b1;
      cycle();
      FrameTick = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cycle();
      cycle();
      reset_n = 1'b1;
      cycle();
   endtask

   task automatic do_start();
      Start = 1'b1;
      cycle();
      Start = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; Start = 1'b0; Ack = 1'b0; BtnPress = 1'b0; FrameTick = 1'b0;
      cycle();
      chk("rst_x", Bird_X, 300);
      chk("rst_y", Bird_Y, 240);
      chk("rst_v", VertSpeed, 0);
      chk("rst_state", State, 0);
      chk("rst_crashed", Crashed, 0);
      cycle();
      reset_n = 1'b1;
      cycle();

      // INIT ignores ticks, flaps and Ack
      do_tick(1'b1);
      BtnPress = 1'b0; Ack = 1'b1;
      cycle();
      Ack = 1'b0;
      chk("init_y", Bird_Y, 240);
      chk("init_v", VertSpeed, 0);
      chk("init_state", State, 0);

      do_start();
      chk("start_state", State, 1);

      do_tick(1'b0);
      chk("t1_v", VertSpeed, 8);  chk("t1_acc", dut.y_acc_q, 3840); chk("t1_y", Bird_Y, 240);
      do_tick(1'b0);
      chk("t2_v", VertSpeed, 16); chk("t2_acc", dut.y_acc_q, 3848); chk("t2_y", Bird_Y, 240);
      do_tick(1'b0);
      chk("t3_v", VertSpeed, 24); chk("t3_acc", dut.y_acc_q, 3864); chk("t3_y", Bird_Y, 241);

      Ack = 1'b1; Start = 1'b1;
      cycle();
      Ack = 1'b0; Start = 1'b0;
      chk("ack_in_flight", State, 1);

      for (int n = 4; n <= 25; n++) begin
         do_tick(1'b0);
         chk("freefall_v", VertSpeed, (8 * n > 160) ? 160 : 8 * n);
      end
      chk("freefall_acc", dut.y_acc_q, 6160);
      chk("freefall_y", Bird_Y, 385);

      // rising edge coincident with tick, then held for nine more frames
      do_tick(1'b1);
      chk("flap_v", VertSpeed, -96);
      chk("flap_y", Bird_Y, 395);
      for (int k = 1; k <= 9; k++) begin
         do_tick(1'b1);
         chk("held_v", VertSpeed, -96 + 8 * k);
      end
      chk("held_y", Bird_Y, 359);
      BtnPress = 1'b0;
      cycle();

      // asynchronous reset between edges
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_x", Bird_X, 300);
      chk("arst_y", Bird_Y, 240);
      chk("arst_v", VertSpeed, 0);
      chk("arst_state", State, 0);
      chk("arst_crashed", Crashed, 0);
      cycle();
      reset_n = 1'b1;
      cycle();

      do_start();
      for (int k = 1; k <= 42; k++) begin
         do_tick(1'b1);
         BtnPress = 1'b0;
         cycle();
         chk("climb_y", Bird_Y, (k <= 41) ? 240 - 6 * (k - 1) : 0);
         chk("climb_v", VertSpeed, -96);
      end
      chk("ceil_acc", dut.y_acc_q, 0);
      do_tick(1'b0);
      chk("ceil_v", VertSpeed, 0);
      chk("ceil_y", Bird_Y, 0);
      chk("ceil_acc2", dut.y_acc_q, 0);
      do_tick(1'b0);
      chk("ceil_v2", VertSpeed, 8);
      chk("ceil_y2", Bird_Y, 0);

      for (int k = 1; k <= 55; k++) do_tick(1'b0);
      chk("prefloor_crashed", Crashed, 0);
      chk("prefloor_y", Bird_Y, 455);
      chk("prefloor_v", VertSpeed, 160);
      do_tick(1'b0);
      chk("floor_crashed", Crashed, 1);
      chk("floor_y", Bird_Y, 464);
      chk("floor_v", VertSpeed, 0);
      chk("floor_state", State, 2);

      Start = 1'b1;
      do_tick(1'b1);
      BtnPress = 1'b0;
      cycle();
      do_tick(1'b1);
      cycle();
      Start = 1'b0; BtnPress = 1'b0;
      cycle();
      chk("frozen_y", Bird_Y, 464);
      chk("frozen_v", VertSpeed, 0);
      chk("frozen_state", State, 2);
      chk("frozen_crashed", Crashed, 1);

      Ack = 1'b1;
      cycle();
      Ack = 1'b0;
      chk("ack_state", State, 0);
      chk("ack_y", Bird_Y, 240);
      chk("ack_v", VertSpeed, 0);
      chk("ack_crashed", Crashed, 0);
      chk("ack_acc", dut.y_acc_q, 3840);

      do_start();
      do_tick(1'b1);
      BtnPress = 1'b0;
      chk("cd_t1", VertSpeed, -96);
      do_tick(1'b0);
      chk("cd_t2", VertSpeed, -88);
      do_tick(1'b0);
      chk("cd_t3", VertSpeed, -80);
      BtnPress = 1'b1;
      cycle();
      BtnPress = 1'b0;
      cycle();
      do_tick(1'b0);
`ifdef FLAP_COOLDOWN_EN
      chk("cd_t4", VertSpeed, -72);
`else
      chk("cd_t4", VertSpeed, -96);
`endif
      do_tick(1'b0);
`ifdef FLAP_COOLDOWN_EN
      chk("cd_t5", VertSpeed, -64);
`else
      chk("cd_t5", VertSpeed, -88);
`endif
      BtnPress = 1'b1;
      cycle();
      BtnPress = 1'b0;
      cycle();
      do_tick(1'b0);
      chk("cd_t6", VertSpeed, -96);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
